// File: rtl/if_stage_pkg.sv
// Shared payload types for the instruction-fetch stage and its IF/ID consumer.
package if_stage_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_flow_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory channel: valid/ready fetch request, in-order response words.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC, credit-limited imem requests, FWFT response FIFO, redirect flush.
// Optional IF_BUBBLE_NOP_EN presents a NOP with pc 0 on outflow whenever the FIFO is empty.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  if_stage_if.master  imem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output if_id_flow_t outflow
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  if_id_flow_t      mem_q [FIFO_DEPTH];

  logic        req_valid_c;
  logic        accept_c;
  logic        push_c;
  logic        pop_c;
  logic [31:0] resp_pc_c;

  // Next-state logic; redirect is applied last so it overrides everything else.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    req_valid_c = reset_n && (state_q == ST_RUN) && !redirect_valid &&
                  ((SUM_W'(outstanding_q) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH));
    accept_c    = req_valid_c && imem.imem_req_ready;
    pop_c       = (count_q != '0) && !stall && !redirect_valid;
    push_c      = imem.imem_resp_valid && (state_q == ST_RUN) && !redirect_valid;
    // In RUN every outstanding fetch is sequential, so the oldest one sits this far behind pc.
    resp_pc_c   = pc_q - (32'(outstanding_q) << 2);

    outstanding_d = outstanding_q + CNT_W'(accept_c) - CNT_W'(imem.imem_resp_valid);
    if (accept_c) begin
      pc_d = pc_q + 32'd4;
    end

    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    if ((state_q == ST_FLUSH) && imem.imem_resp_valid) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (drop_cnt_d == '0) begin
        state_d = ST_RUN;
      end
    end

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CNT_W'(imem.imem_resp_valid) + CNT_W'(accept_c);
      state_d    = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      mem_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push_c) begin
        mem_q[wr_ptr_q] <= if_id_flow_t'{pc: resp_pc_c, instr: imem.imem_resp_data};
      end
    end
  end

  assign imem.imem_req_valid = req_valid_c;
  assign imem.imem_req_addr  = pc_q;
  assign out_valid           = (count_q != '0);

`ifdef IF_BUBBLE_NOP_EN
  assign outflow = (count_q != '0) ? mem_q[rd_ptr_q]
                                   : if_id_flow_t'{pc: 32'h0000_0000, instr: NOP_INSTR};
`else
  assign outflow = mem_q[rd_ptr_q];
`endif

  // The credit rule must keep responses from ever meeting a full FIFO or an empty request count.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    imem.imem_resp_valid |-> (count_q != CNT_W'(FIFO_DEPTH)));
  a_no_spurious : assert property (@(posedge clk) disable iff (!reset_n)
    imem.imem_resp_valid |-> (outstanding_q != '0));

endmodule
